// File: rtl/cycle_timer_pager.sv
// Start/stop elapsed-cycle timer: snapshot is converted to BCD by shift-add-3 and shown page by page.
// Define CT_LEADING_BLANK_EN to skip leading all-zero pages while paging.
module cycle_timer_pager #(
   parameter int CNT_W    = 36,
   parameter int DIGITS   = 11,
   parameter int GROUP    = 3,
   parameter int PAGE_DIV = 25000000,
   localparam int NPAGES  = (DIGITS + GROUP - 1) / GROUP,
   localparam int IDX_W   = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
   input  logic                 CLOCK_50,
   input  logic                 reset,
   input  logic                 toggleBtn,
   output logic [4*GROUP-1:0]   page_bcd,
   output logic [IDX_W-1:0]     page_idx,
   output logic                 running,
   output logic                 busy,
   output logic                 overflow
);

   localparam int PAD_W = 4 * NPAGES * GROUP;
   localparam int TMR_W = (PAGE_DIV > 1) ? $clog2(PAGE_DIV) : 1;
   localparam int BIT_W = $clog2(CNT_W + 1);
   localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(PAGE_DIV - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(CNT_W - 1);
   localparam logic [IDX_W-1:0] LAST_PAGE = IDX_W'(NPAGES - 1);

   localparam logic [1:0] STOPPED = 2'd0;
   localparam logic [1:0] RUN     = 2'd1;
   localparam logic [1:0] CONVERT = 2'd2;
   localparam logic [1:0] SHOW    = 2'd3;

   // 10^DIGITS >= 2^CNT_W  <=>  DIGITS * log2(10) >= CNT_W
   generate
      if (longint'(DIGITS) * 3321928 < longint'(CNT_W) * 1000000) begin : g_digits_too_small
         $error("cycle_timer_pager: DIGITS cannot hold a CNT_W-bit count");
      end
   endgenerate

   logic [1:0]          state;
   logic                sync1, sync2, sync3;
   logic                toggle_ev;
   logic [CNT_W-1:0]    cnt, cnt_inc, shift_reg, shift_next;
   logic [4*DIGITS-1:0] bcd, bcd_adj, bcd_next;
   logic [BIT_W-1:0]    bit_cnt;
   logic [TMR_W-1:0]    page_tmr;
   logic [IDX_W-1:0]    page_reg, page_inc, next_page, first_page_next;
   logic [PAD_W-1:0]    padded;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         sync3 <= 1'b1;
      end else begin
         sync1 <= toggleBtn;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign toggle_ev = sync3 & ~sync2;
   assign cnt_inc   = cnt + 1'b1;
   assign page_inc  = page_reg + 1'b1;

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd[4*i +: 4] > 4'd4) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
      bcd_next   = {bcd_adj[4*DIGITS-2:0], shift_reg[CNT_W-1]};
      shift_next = {shift_reg[CNT_W-2:0], 1'b0};
   end

`ifdef CT_LEADING_BLANK_EN
   logic [IDX_W-1:0] first_page;

   // First page holding a nonzero digit; the last page is never skipped.
   function automatic logic [IDX_W-1:0] first_nonblank(input logic [4*DIGITS-1:0] v);
      logic [PAD_W-1:0] p;
      logic             found;
      first_nonblank = LAST_PAGE;
      p = '0;
      p[4*DIGITS-1:0] = v;
      found = 1'b0;
      for (int i = 0; i < NPAGES - 1; i++) begin
         if (!found && p[(NPAGES-1-i)*4*GROUP +: 4*GROUP] != '0) begin
            first_nonblank = IDX_W'(i);
            found = 1'b1;
         end
      end
   endfunction

   assign first_page      = first_nonblank(bcd);
   assign first_page_next = first_nonblank(bcd_next);
   assign next_page       = (page_reg == LAST_PAGE || page_inc < first_page) ? first_page : page_inc;
`else
   assign first_page_next = '0;
   assign next_page       = (page_reg == LAST_PAGE) ? '0 : page_inc;
`endif

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state     <= STOPPED;
         cnt       <= '0;
         shift_reg <= '0;
         bcd       <= '0;
         bit_cnt   <= '0;
         page_tmr  <= '0;
         page_reg  <= '0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            STOPPED, SHOW: begin
               if (toggle_ev) begin
                  state    <= RUN;
                  cnt      <= '0;
                  overflow <= 1'b0;
                  page_reg <= '0;
                  page_tmr <= '0;
               end else if (page_tmr == LAST_TICK) begin
                  page_tmr <= '0;
                  page_reg <= next_page;
               end else begin
                  page_tmr <= page_tmr + 1'b1;
               end
            end
            RUN: begin
               // The exit edge still counts, so a wrap on that edge snapshots 0.
               cnt <= cnt_inc;
               if (&cnt) overflow <= 1'b1;
               if (toggle_ev) begin
                  state     <= CONVERT;
                  shift_reg <= cnt_inc;
                  bcd       <= '0;
                  bit_cnt   <= '0;
               end
            end
            default: begin
               shift_reg <= shift_next;
               bcd       <= bcd_next;
               bit_cnt   <= bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  state    <= SHOW;
                  page_reg <= first_page_next;
                  page_tmr <= '0;
               end
            end
         endcase
      end
   end

   assign running = (state == RUN);
   assign busy    = (state == CONVERT);

   always_comb begin
      padded = '1;
      padded[4*DIGITS-1:0] = bcd;
      if (state == RUN || state == CONVERT) begin
         page_bcd = {GROUP{4'hE}};
         page_idx = '0;
      end else begin
         page_bcd = padded[(NPAGES-1-int'(page_reg))*4*GROUP +: 4*GROUP];
         page_idx = page_reg;
      end
   end

endmodule

// File: doc/cycle_timer_pager.md
CYCLE_TIMER_PAGER -- requirements
Module: cycle_timer_pager

Interface
REQ-001 CNT_W, 36, elapsed-cycle counter width in bits.
REQ-002 DIGITS, 11, BCD digits produced; SHALL satisfy 10^DIGITS >= 2^CNT_W, else elaboration error.
REQ-003 GROUP, 3, digits shown per display page.
REQ-004 PAGE_DIV, 25000000, clock cycles each page is held.
REQ-005 CLOCK_50  in  1  sole clock, all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 toggleBtn  in  1  active-low start/stop button, asynchronous to CLOCK_50.
REQ-008 page_bcd  out  4*GROUP  BCD digits of current page, MS digit in top nibble; 4'hF = blank.
REQ-009 page_idx  out  clog2(NPAGES)  index of current page, NPAGES = ceil(DIGITS/GROUP); 0 = most significant page.
REQ-010 running  out  1  high while counting.
REQ-011 busy  out  1  high during BCD conversion.
REQ-012 overflow  out  1  sticky counter wrap flag.

Function
REQ-013 toggleBtn SHALL pass a 2-flop synchroniser plus falling-edge detector; one press = one toggle event, registered 3 rising edges after the fall.
REQ-014 States SHALL be STOPPED, RUN, CONVERT, SHOW.
REQ-015 STOPPED/SHOW + toggle -> RUN with counter cleared to 0 and overflow cleared.
REQ-016 RUN: counter SHALL increment by 1 every cycle; counter value equals cycles spent in RUN.
REQ-017 RUN + toggle -> CONVERT; counter frozen and snapshotted on that edge.
REQ-018 Counter at 2^CNT_W-1 SHALL wrap to 0 and set overflow, held until next RUN entry or reset.
REQ-019 CONVERT SHALL run sequential shift-add-3 conversion of exactly CNT_W cycles, busy high throughout, then -> SHOW.
REQ-020 Toggle events during CONVERT SHALL be discarded.
REQ-021 In RUN and CONVERT, page_bcd SHALL be all 4'hE (dash code), page_idx 0.
REQ-022 SHOW: page_idx starts at 0, advances every PAGE_DIV cycles, wraps NPAGES-1 -> 0.
REQ-023 Digit positions above DIGITS-1 in page 0 SHALL read 4'hF.
REQ-024 Page timer SHALL restart at 0 on every entry to SHOW.
REQ-025 Toggle coincident with counter wrap: wrap and overflow take effect, then transition to CONVERT with value 0.

Reset
REQ-026 reset SHALL force STOPPED, counter 0, BCD register 0, page_idx 0, page timer 0, running 0, busy 0, overflow 0, synchroniser flops 1.
REQ-027 In STOPPED, page_bcd SHALL show all-zero digits of page page_idx, paging as in SHOW.
REQ-028 reset asserted mid-RUN or mid-CONVERT SHALL abandon the operation; no partial BCD visible after release.

Configuration
REQ-029 Macro CT_LEADING_BLANK_EN.
REQ-030 Defined: in SHOW/STOPPED, pages whose digits are all zero and that precede the first nonzero page SHALL be skipped; last page never skipped; start page is first non-skipped page.
REQ-031 Undefined: every page is shown in sequence regardless of content.

Verification (CNT_W=12, DIGITS=4, GROUP=2, PAGE_DIV=4)
REQ-032 Reset released, no press -> running 0, page_bcd 8'h00, page_idx toggles 0/1 every 4 cycles.
REQ-033 Press, 1234 cycles in RUN, press -> busy high 12 cycles, then page_bcd 8'h12 (idx 0) and 8'h34 (idx 1) alternating every 4 cycles.
REQ-034 4100 cycles in RUN, stop -> overflow 1, pages 8'h00/8'h04; with CT_LEADING_BLANK_EN only 8'h04 at idx 1 continuously.
REQ-035 Second press 2 cycles into CONVERT -> ignored; SHOW reached after 12 cycles, running stays 0.
REQ-036 reset pulsed at RUN cycle 500 -> all outputs at REQ-026 values next edge; following press/press after 7 cycles -> pages 8'h00/8'h07.
